io_switch_debounce: RTL and testbench

Input-conditioning stage that sits directly upstream of the I/O read-port mux of the single-cycle CPU. It synchronizes two raw 5-bit switch groups from the board into the `io_clk` domain and debounces each group. It presents them as zero-extended 32-bit words (`in_port0`, `in_port1`) that the I/O read path returns on CPU loads. Upper bits 31:5 are driven to constant zero here, so the downstream stage only muxes.

---
 rtl/io_switch_debounce.sv | 105 ++++++++++
 tb/tb_io_switch_debounce.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/io_switch_debounce.sv
// Two-group switch input conditioner: 2-flop synchronizer plus debounce per group,
// zero-extended to 32 bits. Optional sticky change flags with IO_SWITCH_CHANGE_FLAG_EN.
module io_switch_debounce #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             io_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw0_raw,
  input  logic [WIDTH-1:0] sw1_raw,
`ifdef IO_SWITCH_CHANGE_FLAG_EN
  input  logic [1:0]       in_changed_clr,
  output logic [1:0]       in_changed,
`endif
  output logic [31:0]      in_port0,
  output logic [31:0]      in_port1
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] raw_w    [2];
  logic [WIDTH-1:0] stable_w [2];
`ifdef IO_SWITCH_CHANGE_FLAG_EN
  logic [1:0]       update_w;
`endif

  assign raw_w[0] = sw0_raw;
  assign raw_w[1] = sw1_raw;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_grp
      logic [WIDTH-1:0] s1_reg;
      logic [WIDTH-1:0] s2_reg;
      logic [WIDTH-1:0] cand_reg;
      logic [WIDTH-1:0] cand_next;
      logic [WIDTH-1:0] stable_reg;
      logic [WIDTH-1:0] stable_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;

      // Any candidate change restarts the count, so bounces never reach the output.
      always_comb begin
        cand_next   = cand_reg;
        stable_next = stable_reg;
        cnt_next    = cnt_reg;
        if (s2_reg != cand_reg) begin
          cand_next = s2_reg;
          cnt_next  = '0;
        end else if (cand_reg != stable_reg) begin
          if (cnt_reg == CNT_LAST) begin
            stable_next = cand_reg;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else begin
          cnt_next = '0;
        end
      end

      always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
          s1_reg     <= '0;
          s2_reg     <= '0;
          cand_reg   <= '0;
          cnt_reg    <= '0;
          stable_reg <= '0;
        end else begin
          s1_reg     <= raw_w[gi];
          s2_reg     <= s1_reg;
          cand_reg   <= cand_next;
          cnt_reg    <= cnt_next;
          stable_reg <= stable_next;
        end
      end

      assign stable_w[gi] = stable_reg;

`ifdef IO_SWITCH_CHANGE_FLAG_EN
      assign update_w[gi] = (s2_reg == cand_reg) && (cand_reg != stable_reg) &&
                            (cnt_reg == CNT_LAST);
`endif
    end
  endgenerate

  assign in_port0 = {{(32-WIDTH){1'b0}}, stable_w[0]};
  assign in_port1 = {{(32-WIDTH){1'b0}}, stable_w[1]};

`ifdef IO_SWITCH_CHANGE_FLAG_EN
  logic [1:0] in_changed_reg;

  // A set on the same edge as a clear takes precedence.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      in_changed_reg <= 2'b00;
    end else begin
      in_changed_reg <= update_w | (in_changed_reg & ~in_changed_clr);
    end
  end

  assign in_changed = in_changed_reg;
`endif

endmodule

// File: tb/tb_io_switch_debounce.sv
// Table-driven bench for io_switch_debounce (WIDTH=5, D=4) with an expected-value queue;
// flag checks compile in when IO_SWITCH_CHANGE_FLAG_EN is defined.
module tb_io_switch_debounce;

  logic        io_clk;
  logic        reset;
  logic [4:0]  sw0_raw;
  logic [4:0]  sw1_raw;
  logic [31:0] in_port0;
  logic [31:0] in_port1;
  logic [1:0]  in_changed_clr;
`ifdef IO_SWITCH_CHANGE_FLAG_EN
  logic [1:0]  in_changed;
`endif

  io_switch_debounce #(
    .WIDTH          (5),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4)
  ) dut (
    .io_clk        (io_clk),
    .reset         (reset),
    .sw0_raw       (sw0_raw),
    .sw1_raw       (sw1_raw),
`ifdef IO_SWITCH_CHANGE_FLAG_EN
    .in_changed_clr(in_changed_clr),
    .in_changed    (in_changed),
`endif
    .in_port0      (in_port0),
    .in_port1      (in_port1)
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  // One segment: drive sw0/sw1, hold for 'edges' rising edges; ports must read
  // mid0/mid1 after every edge but the last, and end0/end1 after the last.
  typedef struct {
    logic [4:0]  sw0;
    logic [4:0]  sw1;
    int          edges;
    logic [31:0] mid0;
    logic [31:0] mid1;
    logic [31:0] end0;
    logic [31:0] end1;
  } seg_t;

  typedef struct {
    int          seg;
    int          edge_n;
    logic [31:0] p0;
    logic [31:0] p1;
  } exp_t;

  exp_t exp_q[$];
  seg_t tbl[16];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
    end else begin
      e = exp_q.pop_front();
      check($sformatf("seg%0d_edge%0d_in_port0", e.seg, e.edge_n), in_port0, e.p0);
      check($sformatf("seg%0d_edge%0d_in_port1", e.seg, e.edge_n), in_port1, e.p1);
    end
  endtask

  task automatic run_seg(input int id, input seg_t s);
    exp_t e;
    sw0_raw = s.sw0;
    sw1_raw = s.sw1;
    for (int k = 1; k <= s.edges; k++) begin
      e.seg    = id;
      e.edge_n = k;
      e.p0     = (k == s.edges) ? s.end0 : s.mid0;
      e.p1     = (k == s.edges) ? s.end1 : s.mid1;
      exp_q.push_back(e);
      @(posedge io_clk);
      #1;
      pop_check();
    end
    $display("seg %0d sw0=%h sw1=%h edges=%0d in_port0=%h in_port1=%h",
             id, s.sw0, s.sw1, s.edges, in_port0, in_port1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    seg_t tmp;
    // clean change on group 0
    tbl[0]  = '{5'h0A, 5'h00, 6, 32'h0,  32'h0,  32'h0,  32'h0};
    tbl[1]  = '{5'h0A, 5'h00, 1, 32'h0,  32'h0,  32'hA,  32'h0};
    // 4-edge glitch on group 1 is filtered
    tbl[2]  = '{5'h0A, 5'h11, 4, 32'hA,  32'h0,  32'hA,  32'h0};
    tbl[3]  = '{5'h0A, 5'h00, 6, 32'hA,  32'h0,  32'hA,  32'h0};
    // 5-edge pulse propagates at edge 7, then the return to 0 at edge 12
    tbl[4]  = '{5'h0A, 5'h11, 5, 32'hA,  32'h0,  32'hA,  32'h0};
    tbl[5]  = '{5'h0A, 5'h00, 2, 32'hA,  32'h0,  32'hA,  32'h11};
    tbl[6]  = '{5'h0A, 5'h00, 5, 32'hA,  32'h11, 32'hA,  32'h0};
    // group 0 back to zero
    tbl[7]  = '{5'h00, 5'h00, 7, 32'hA,  32'h0,  32'h0,  32'h0};
    // bounce 03/00 every 2 cycles, then settle at 03
    tbl[8]  = '{5'h03, 5'h00, 2, 32'h0,  32'h0,  32'h0,  32'h0};
    tbl[9]  = '{5'h00, 5'h00, 2, 32'h0,  32'h0,  32'h0,  32'h0};
    tbl[10] = '{5'h03, 5'h00, 2, 32'h0,  32'h0,  32'h0,  32'h0};
    tbl[11] = '{5'h00, 5'h00, 2, 32'h0,  32'h0,  32'h0,  32'h0};
    tbl[12] = '{5'h03, 5'h00, 6, 32'h0,  32'h0,  32'h0,  32'h0};
    tbl[13] = '{5'h03, 5'h00, 1, 32'h0,  32'h0,  32'h3,  32'h0};
    // simultaneous change on both groups
    tbl[14] = '{5'h1F, 5'h1F, 6, 32'h3,  32'h0,  32'h3,  32'h0};
    tbl[15] = '{5'h1F, 5'h1F, 1, 32'h3,  32'h0,  32'h1F, 32'h1F};

    reset          = 1'b1;
    sw0_raw        = 5'h00;
    sw1_raw        = 5'h00;
    in_changed_clr = 2'b00;
    #12;
    check("reset_in_port0", in_port0, 32'h0);
    check("reset_in_port1", in_port1, 32'h0);
    @(posedge io_clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_seg(i, tbl[i]);
    end

    // asynchronous reset mid-cycle while both ports hold 1F
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_in_port0", in_port0, 32'h0);
    check("async_reset_in_port1", in_port1, 32'h0);
    $display("async reset asserted in_port0=%h in_port1=%h", in_port0, in_port1);
    @(posedge io_clk);
    #3;
    reset = 1'b0;
    tmp = '{5'h1F, 5'h1F, 6, 32'h0, 32'h0, 32'h0,  32'h0};
    run_seg(100, tmp);
    tmp = '{5'h1F, 5'h1F, 1, 32'h0, 32'h0, 32'h1F, 32'h1F};
    run_seg(101, tmp);

`ifdef IO_SWITCH_CHANGE_FLAG_EN
    check("flag_after_redebounce", {30'b0, in_changed}, 32'h3);
    in_changed_clr = 2'b11;
    @(posedge io_clk);
    #1;
    check("flag_cleared", {30'b0, in_changed}, 32'h0);
    in_changed_clr = 2'b00;
    tmp = '{5'h00, 5'h1F, 6, 32'h1F, 32'h1F, 32'h1F, 32'h1F};
    run_seg(200, tmp);
    check("flag_before_update", {30'b0, in_changed}, 32'h0);
    tmp = '{5'h00, 5'h1F, 1, 32'h1F, 32'h1F, 32'h0, 32'h1F};
    run_seg(201, tmp);
    check("flag_set_g0", {30'b0, in_changed}, 32'h1);
    tmp = '{5'h05, 5'h1F, 6, 32'h0, 32'h1F, 32'h0, 32'h1F};
    run_seg(202, tmp);
    in_changed_clr = 2'b01;
    tmp = '{5'h05, 5'h1F, 1, 32'h0, 32'h1F, 32'h5, 32'h1F};
    run_seg(203, tmp);
    check("flag_set_wins", {30'b0, in_changed}, 32'h1);
    tmp = '{5'h05, 5'h1F, 1, 32'h5, 32'h1F, 32'h5, 32'h1F};
    run_seg(204, tmp);
    check("flag_clear_idle", {30'b0, in_changed}, 32'h0);
    in_changed_clr = 2'b00;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
